// File: rtl/pipeline_interlock.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_interlock
// Brief    : IF/ID register with load-use stall and branch-flush interlock,
//            stall/flush performance counters and a sticky stall-timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_interlock #(
  parameter int unsigned STALL_LIMIT = 4,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  input  logic        if_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic        pc_write,
  output logic        idex_bubble,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic        stall_timeout
);

  localparam int unsigned c_rl_w = $clog2(STALL_LIMIT + 1);
  localparam logic [c_rl_w-1:0] c_run_max  = c_rl_w'(STALL_LIMIT);
  localparam logic [c_rl_w-1:0] c_run_last = c_rl_w'(STALL_LIMIT - 1);

  localparam logic [1:0] c_st_run     = 2'd0;
  localparam logic [1:0] c_st_stalled = 2'd1;
  localparam logic [1:0] c_st_flushed = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       id_pc_q, id_pc_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic              id_valid_q, id_valid_d;
  logic [c_rl_w-1:0] run_len_q, run_len_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic [15:0]       flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;
  logic              w_stall_eff;

  // A stall against a bubble in ID has nothing to protect, and flush wins.
  assign w_stall_eff = stall & id_valid_q & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_st_run;
      id_pc_q     <= 32'd0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      run_len_q   <= '0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      run_len_q   <= run_len_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = c_st_run;
    if (flush)
      state_d = c_st_flushed;
    else if (w_stall_eff)
      state_d = c_st_stalled;
  end

  always_comb begin
    pc_write    = ~reset & ~w_stall_eff;
    idex_bubble = reset | w_stall_eff | flush;
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_pc_d    = 32'd0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (!w_stall_eff) begin
      id_pc_d    = if_pc;
      id_instr_d = if_instruction;
      id_valid_d = if_valid;
    end
  end

  // Outside STALLED the run length is always zero, so a fresh stall starts at 1.
  always_comb begin
    run_len_d = '0;
    if (w_stall_eff) begin
      if (state_q != c_st_stalled)
        run_len_d = c_rl_w'(1);
      else if (run_len_q == c_run_max)
        run_len_d = run_len_q;
      else
        run_len_d = run_len_q + c_rl_w'(1);
    end
  end

  always_comb begin
    timeout_d   = timeout_q | (w_stall_eff & (run_len_q == c_run_last));
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall_eff && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  assign id_pc          = id_pc_q;
  assign id_instruction = id_instr_q;
  assign id_valid       = id_valid_q;
  assign stall_count    = stall_cnt_q;
  assign flush_count    = flush_cnt_q;
  assign stall_timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_interlock.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_interlock
// Brief    : Directed self-checking bench for pipeline_interlock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_interlock;

  localparam logic [31:0] c_nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, if_valid;
  logic [31:0] if_pc, if_instruction;
  logic [31:0] id_pc, id_instruction;
  logic        id_valid, pc_write, idex_bubble, stall_timeout;
  logic [15:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_interlock #(.STALL_LIMIT(4), .NOP_INSTR(32'h00000013)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_valid       (if_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .id_valid       (id_valid),
    .pc_write       (pc_write),
    .idex_bubble    (idex_bubble),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .stall_timeout  (stall_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] pc,
                       input logic [31:0] ins, input logic v);
    stall = s; flush = f; if_pc = pc; if_instruction = ins; if_valid = v;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1);
    tick(); tick();
    chk("rst_id_pc",    id_pc, 32'd0);
    chk("rst_id_instr", id_instruction, c_nop);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_cnts",     {stall_count, flush_count}, 32'd0);
    chk("rst_timeout",  {31'd0, stall_timeout}, 32'd0);
    chk("rst_pcw_bub",  {30'd0, pc_write, idex_bubble}, 32'd1);
    reset = 1'b0;
    #1;
    chk("run_pcw_bub",  {30'd0, pc_write, idex_bubble}, 32'd2);

    // Valid instruction into ID, then a one-cycle load-use stall
    drive(1'b0, 1'b0, 32'h100, 32'h0000_000A, 1'b1);
    tick();
    chk("load_pc", id_pc, 32'h100);
    drive(1'b1, 1'b0, 32'h104, 32'h0000_000B, 1'b1);
    chk("stall_pcw_bub", {30'd0, pc_write, idex_bubble}, 32'd1);
    tick();
    chk("stall_hold_pc",    id_pc, 32'h100);
    chk("stall_hold_instr", id_instruction, 32'h0000_000A);
    chk("stall_cnt1",       {16'd0, stall_count}, 32'd1);
    drive(1'b0, 1'b0, 32'h104, 32'h0000_000B, 1'b1);
    chk("unstall_pcw", {31'd0, pc_write}, 32'd1);
    tick();
    chk("resume_instr", id_instruction, 32'h0000_000B);
    chk("resume_pc",    id_pc, 32'h104);

    // Flush beats stall in the same cycle
    do_reset();
    drive(1'b0, 1'b0, 32'h180, 32'h0000_00C0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'h184, 32'h0000_00C4, 1'b1);
    chk("sf_pcw_bub", {30'd0, pc_write, idex_bubble}, 32'd3);
    tick();
    chk("sf_instr", id_instruction, c_nop);
    chk("sf_pc",    id_pc, 32'd0);
    chk("sf_valid", {31'd0, id_valid}, 32'd0);
    chk("sf_cnts",  {stall_count, flush_count}, 32'h0000_0001);

    // Stall against a bubble in ID is ignored
    drive(1'b1, 1'b0, 32'h200, 32'h0000_000D, 1'b1);
    chk("bub_pcw_bub", {30'd0, pc_write, idex_bubble}, 32'd2);
    tick();
    chk("bub_load_pc", id_pc, 32'h200);
    chk("bub_valid",   {31'd0, id_valid}, 32'd1);
    chk("bub_cnt",     {16'd0, stall_count}, 32'd0);

    // Four consecutive stalls raise the sticky timeout
    drive(1'b1, 1'b0, 32'h204, 32'h0000_000E, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_edge%0d", i), {31'd0, stall_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk("to_hold_pc", id_pc, 32'h200);
    chk("to_cnt",     {16'd0, stall_count}, 32'd4);
    drive(1'b0, 1'b0, 32'h204, 32'h0000_000E, 1'b1);
    tick();
    chk("to_sticky", {31'd0, stall_timeout}, 32'd1);
    drive(1'b1, 1'b0, 32'h208, 32'h0000_000F, 1'b1);
    chk("to_still_stalls", {31'd0, pc_write}, 32'd0);
    tick();
    chk("to_still_held", id_pc, 32'h204);

    // Reset during STALLED with stall still asserted
    reset = 1'b1;
    #1;
    chk("rs_pcw_bub", {30'd0, pc_write, idex_bubble}, 32'd1);
    tick();
    chk("rs_valid",   {31'd0, id_valid}, 32'd0);
    chk("rs_instr",   id_instruction, c_nop);
    chk("rs_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("rs_cnts",    {stall_count, flush_count}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h300, 32'h0000_0030, 1'b1);
    chk("rs_post_pcw", {31'd0, pc_write}, 32'd1);
    tick();
    chk("rs_post_pc",  id_pc, 32'h300);

    // Stall counter saturation
    do_reset();
    drive(1'b0, 1'b0, 32'h400, 32'h0000_0040, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h404, 32'h0000_0044, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, stall_count}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", {16'd0, stall_count}, 32'h0000_FFFF);
    tick(); tick(); tick();
    chk("sat_hold", {16'd0, stall_count}, 32'h0000_FFFF);
    chk("sat_pc",   id_pc, 32'h400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_interlock.md
PIPELINE_INTERLOCK -- requirements
Module: pipeline_interlock

Interface
REQ-001 SHALL have parameter: STALL_LIMIT, default 4, consecutive-stall count at which stall_timeout sets.
REQ-002 SHALL have parameter: NOP_INSTR, default 32'h00000013, encoding loaded into IF/ID on reset and on flush.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: stall  input  1  load-use stall request from the hazard detector, combinational, same cycle.
REQ-006 SHALL have port: flush  input  1  taken-branch/jump flush request from EX.
REQ-007 SHALL have ports: if_pc  input  32  and  if_instruction  input  32  fetch-stage PC and instruction.
REQ-008 SHALL have port: if_valid  input  1  fetch output valid.
REQ-009 SHALL have ports: id_pc  output  32,  id_instruction  output  32,  id_valid  output  1  registered IF/ID contents.
REQ-010 SHALL have port: pc_write  output  1  PC register write enable (combinational).
REQ-011 SHALL have port: idex_bubble  output  1  zero all ID/EX control fields this cycle (combinational).
REQ-012 SHALL have ports: stall_count  output  16,  flush_count  output  16  saturating performance counters.
REQ-013 SHALL have port: stall_timeout  output  1  sticky error flag.

Function
REQ-014 SHALL compute stall_eff = stall & id_valid & ~flush; a request against a bubble in ID is ignored.
REQ-015 SHALL drive pc_write = ~reset & ~stall_eff and idex_bubble = reset | stall_eff | flush.
REQ-016 SHALL, on an edge with flush=1, load id_instruction=NOP_INSTR, id_pc=0, id_valid=0 (flush beats stall).
REQ-017 SHALL, on an edge with stall_eff=1, hold id_pc, id_instruction, id_valid unchanged.
REQ-018 SHALL otherwise load id_pc=if_pc, id_instruction=if_instruction, id_valid=if_valid.
REQ-019 SHALL implement FSM states RUN, STALLED, FLUSHED.
REQ-020 SHALL transition from any state: flush -> FLUSHED; else stall_eff -> STALLED; else -> RUN.
REQ-021 SHALL keep a consecutive-stall counter run_len: +1 per stall_eff edge, cleared on any edge with stall_eff=0, saturating at STALL_LIMIT.
REQ-022 SHALL set stall_timeout on the edge where stall_eff=1 and run_len==STALL_LIMIT-1; it clears only on reset; stalls stay honoured after timeout.
REQ-023 SHALL increment stall_count on each edge with stall_eff=1 and flush_count on each edge with flush=1; both saturate at 16'hFFFF.
REQ-024 SHALL have latency: IF/ID register updates one cycle after inputs; pc_write/idex_bubble respond same cycle with no register.

Reset
REQ-025 SHALL, on an edge with reset=1, set id_pc=0, id_instruction=NOP_INSTR, id_valid=0, state=RUN, run_len=0, stall_count=0, flush_count=0, stall_timeout=0.
REQ-026 SHALL have reset override flush and stall on the same edge; no counter increments while reset=1.
REQ-027 SHALL, when reset asserts mid-stall, make the first post-reset cycle accept if_* with pc_write=1 (id_valid=0 masks stall).

Verification
REQ-028 SHALL have the bench cover: ID holds valid load, stall=1 for one cycle -> pc_write=0, idex_bubble=1, IF/ID held, stall_count=1, next edge loads new if_instruction.
REQ-029 SHALL have the bench cover: stall=1 and flush=1 same cycle -> pc_write=1, idex_bubble=1, id_instruction=32'h00000013, id_valid=0, flush_count=1, stall_count=0.
REQ-030 SHALL have the bench cover: stall=1 while id_valid=0 -> pc_write=1, idex_bubble=0, IF/ID loads, stall_count unchanged.
REQ-031 SHALL have the bench cover: stall held 4 consecutive cycles (STALL_LIMIT=4) -> stall_timeout=1 after 4th edge, stays 1 after stall drops, cleared only by reset.
REQ-032 SHALL have the bench cover: stall_count preset near 16'hFFFF via 65535+ stalls -> saturates at 16'hFFFF, no wrap to 0.
REQ-033 SHALL have the bench cover: reset asserted during STALLED with stall=1 -> outputs at reset values on next edge; after release, first valid fetch loads with pc_write=1.
